expr_sweep_driver: RTL and testbench
====================================

Name: expr_sweep_driver

Overview:
Initiator-side controller for the start/busy operand interface of the `expr` compute block. It sweeps both 8-bit operands over a programmable rectangular range and issues one start pulse per (a, b) pair. It waits for each computation to finish, then hands every captured (a, b, y) triple downstream on a valid/ready stream. It replaces bench-style stimulus loops with synthesizable sequencing, so `expr` can be exercised and checked on-chip.

Parameters:
W, 8, operand width (a and b)
YW, 16, result width
A_FIRST, 0, first value of a
A_LAST, 255, last value of a (inclusive, A_LAST >= A_FIRST)
B_FIRST, 0, first value of b
B_LAST, 255, last value of b (inclusive, B_LAST >= B_FIRST)
ACK_TIMEOUT, 16, maximum cycles from the start pulse until busy_i must rise

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous, active-high reset
run_i  in  1  level; begin the sweep / allow a restart after done
a_bo  out  W  operand a to expr
b_bo  out  W  operand b to expr
start_o  out  1  one-cycle start pulse to expr
busy_i  in  1  expr busy flag
y_bi  in  YW  expr result; valid while busy_i is low after completion
res_a_bo  out  W  a of the emitted triple
res_b_bo  out  W  b of the emitted triple
res_y_bo  out  YW  captured result
res_valid_o  out  1  triple valid
res_ready_i  in  1  downstream accepts the triple
busy_o  out  1  sweep in progress (state not IDLE/FINISH)
done_o  out  1  sweep completed
err_o  out  1  sticky: ack timeout occurred

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0; a_bo=A_FIRST and b_bo=B_FIRST.
  - Timeout counter and err_o are cleared.
  - Reset mid-operation abandons the current pair immediately, with no further start pulse; an in-flight expr op is simply ignored.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, EMIT, FINISH.
- IDLE: when run_i=1 and busy_i=0, go to ISSUE. If busy_i=1, stay in IDLE (expr is still occupied from an earlier op).
- ISSUE (one cycle):
  - start_o=1; a_bo/b_bo already hold the current pair.
  - Clear the timeout counter and go to WAIT_ACK.
  - start_o is high only in ISSUE, never two consecutive cycles.
- WAIT_ACK:
  - busy_i=1: go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches ACK_TIMEOUT, set err_o=1 and go to FINISH (sweep aborted).
- WAIT_DONE:
  - busy_i=0: register y_bi into res_y_bo and the current a/b into res_a_bo/res_b_bo, set res_valid_o=1, go to EMIT.
  - Capture happens on the first edge where busy_i is seen low.
- EMIT:
  - Hold res_valid_o and the res_* outputs stable until res_ready_i=1.
  - On handshake (valid & ready at an edge):
    - Clear res_valid_o.
    - If a==A_LAST and b==B_LAST, go to FINISH.
    - Else if b==B_LAST: b←B_FIRST, a←a+1, go to ISSUE.
    - Else: b←b+1, go to ISSUE.
  - Comparison happens before the increment, so there is no W-bit wrap; A_LAST=B_LAST=255 terminates correctly.
- FINISH:
  - done_o=1, busy_o=0.
  - When run_i=0: clear done_o, reload a/b to FIRST, go to IDLE.
  - err_o is cleared only by reset.
- a_bo/b_bo are stable from ISSUE through the end of EMIT.
- run_i deasserting mid-sweep has no effect; the sweep completes.
- Throughput: 1 (ISSUE) + ack latency + compute + 1 (capture) + ready wait cycles per pair; with res_ready_i tied high, EMIT lasts one cycle.

Test Plan:
1. A range 0..1, B range 0..2, ready=1, expr model multiplying with 4-cycle busy → exactly 6 triples in order (0,0,0) (0,1,0) (0,2,0) (1,0,0) (1,1,1) (1,2,2); done_o=1; start_o pulses exactly 6 times.
2. Full 0..255 × 0..255 with ready=1 → 65536 triples; last is (0xFF,0xFF,0xFE01); done_o rises after the last handshake; no extra start pulse.
3. Backpressure: res_ready_i low for 10 cycles on the 2nd triple → res_* stable and res_valid_o held high; no start_o until the handshake; sequence is otherwise unchanged.
4. busy_i stuck low after the start pulse, ACK_TIMEOUT=16 → err_o=1 exactly 16 cycles after the start pulse; state goes to FINISH; done_o=1; no further start pulse.
5. rst_i asserted during WAIT_DONE of pair (0,1) → next cycle all outputs are 0 and a_bo=b_bo=0; after release with run_i=1, the sweep restarts at (0,0).
6. run_i held high through FINISH, then dropped for 1 cycle and raised again → done_o clears, and a second full sweep reproduces the identical triple sequence.

Source files
------------

// File: rtl/expr_sweep_driver.sv
// rtl/expr_sweep_driver.sv - sweeps (a, b) over a rectangle, drives expr start/busy, streams (a, b, y) triples
module expr_sweep_driver #(
    parameter int W           = 8,
    parameter int YW          = 16,
    parameter int A_FIRST     = 0,
    parameter int A_LAST      = 255,
    parameter int B_FIRST     = 0,
    parameter int B_LAST      = 255,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          run_i,
    output logic [W-1:0]  a_bo,
    output logic [W-1:0]  b_bo,
    output logic          start_o,
    input  logic          busy_i,
    input  logic [YW-1:0] y_bi,
    output logic [W-1:0]  res_a_bo,
    output logic [W-1:0]  res_b_bo,
    output logic [YW-1:0] res_y_bo,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_EMIT      = 3'd4;
    localparam logic [2:0] S_FINISH    = 3'd5;

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [W-1:0]  A_F     = W'(A_FIRST);
    localparam logic [W-1:0]  A_L     = W'(A_LAST);
    localparam logic [W-1:0]  B_F     = W'(B_FIRST);
    localparam logic [W-1:0]  B_L     = W'(B_LAST);
    localparam logic [CW-1:0] ACK_END = CW'(ACK_TIMEOUT - 1);

    logic [2:0]    state;
    logic [CW-1:0] ack_cnt;

    assign start_o = (state == S_ISSUE);
    assign busy_o  = (state != S_IDLE) && (state != S_FINISH);
    assign done_o  = (state == S_FINISH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            a_bo        <= A_F;
            b_bo        <= B_F;
            ack_cnt     <= '0;
            err_o       <= 1'b0;
            res_a_bo    <= '0;
            res_b_bo    <= '0;
            res_y_bo    <= '0;
            res_valid_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // a busy expr here is left over from an op abandoned by reset
                    if (run_i && !busy_i) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ack_cnt <= '0;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (busy_i) begin
                        state <= S_WAIT_DONE;
                    end else if (ack_cnt == ACK_END) begin
                        err_o <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        ack_cnt <= ack_cnt + CW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!busy_i) begin
                        res_a_bo    <= a_bo;
                        res_b_bo    <= b_bo;
                        res_y_bo    <= y_bi;
                        res_valid_o <= 1'b1;
                        state       <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    // last-value compare precedes the increment, so A_LAST=255 never wraps
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        if (a_bo == A_L && b_bo == B_L) begin
                            state <= S_FINISH;
                        end else if (b_bo == B_L) begin
                            b_bo  <= B_F;
                            a_bo  <= a_bo + W'(1);
                            state <= S_ISSUE;
                        end else begin
                            b_bo  <= b_bo + W'(1);
                            state <= S_ISSUE;
                        end
                    end
                end
                S_FINISH: begin
                    if (!run_i) begin
                        a_bo  <= A_F;
                        b_bo  <= B_F;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_expr_sweep_driver.sv
// tb/tb_expr_sweep_driver.sv - randomized expr model plus reference sequence checking of expr_sweep_driver
module tb_expr_sweep_driver;

    localparam int W  = 8;
    localparam int YW = 16;
    localparam int AF = 254;
    localparam int AL = 255;
    localparam int BF = 253;
    localparam int BL = 255;
    localparam int TO = 16;
    localparam int NPAIRS = (AL - AF + 1) * (BL - BF + 1);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          run_i;
    logic [W-1:0]  a_bo, b_bo, res_a_bo, res_b_bo;
    logic          start_o, busy_i, res_valid_o, res_ready_i, busy_o, done_o, err_o;
    logic [YW-1:0] y_bi, res_y_bo;

    logic [W-1:0] afv, bfv;

    int checks = 0;
    int errors = 0;

    int          starts = 0;
    bit          prev_start = 1'b0;
    bit          dbl_start = 1'b0;
    bit          no_ack = 1'b0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    expr_sweep_driver #(
        .W(W), .YW(YW), .A_FIRST(AF), .A_LAST(AL), .B_FIRST(BF), .B_LAST(BL), .ACK_TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i),
        .a_bo(a_bo), .b_bo(b_bo), .start_o(start_o), .busy_i(busy_i), .y_bi(y_bi),
        .res_a_bo(res_a_bo), .res_b_bo(res_b_bo), .res_y_bo(res_y_bo),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // expr model: sees start at the negedge of the start cycle, random ack latency and compute time
    initial begin
        logic [W-1:0] ma, mb;
        int lat, comp;
        busy_i = 1'b0;
        y_bi   = '0;
        forever begin
            @(negedge clk_i);
            if (start_o && !no_ack) begin
                ma   = a_bo;
                mb   = b_bo;
                lat  = $urandom_range(0, 3);
                comp = $urandom_range(2, 4);
                repeat (1 + lat) @(negedge clk_i);
                busy_i = 1'b1;
                for (int i = 0; i < comp; i++) begin
                    y_bi = YW'($urandom);
                    @(negedge clk_i);
                end
                busy_i = 1'b0;
                y_bi   = {8'd0, ma} * {8'd0, mb};
            end
        end
    end

    always @(negedge clk_i) begin
        if (start_o) starts++;
        if (start_o && prev_start) dbl_start = 1'b1;
        prev_start = start_o;
        if (res_valid_o && res_ready_i) got_q.push_back({res_a_bo, res_b_bo, res_y_bo});
    end

    task automatic do_reset();
        rst_i = 1'b1;
        run_i = 1'b0;
        res_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_bo !== afv) begin errors++; $display("FAIL reset_a: a_bo=%0d required %0d", a_bo, afv); end
        checks++; if (b_bo !== bfv) begin errors++; $display("FAIL reset_b: b_bo=%0d required %0d", b_bo, bfv); end
        checks++; if ({start_o, res_valid_o, busy_o, done_o, err_o} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: start,valid,busy,done,err=%b required 00000",
                               {start_o, res_valid_o, busy_o, done_o, err_o});
        end
        checks++; if ({res_a_bo, res_b_bo, res_y_bo} !== 32'h0) begin
            errors++; $display("FAIL reset_res: res=%h required 0", {res_a_bo, res_b_bo, res_y_bo});
        end
        rst_i = 1'b0;
    endtask

    task automatic test_sweep();
        int n;
        got_q.delete(); starts = 0; dbl_start = 1'b0;
        run_i = 1'b1;
        n = 0;
        while (!done_o && n < 2000) begin @(posedge clk_i); #1; n++; end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL sweep_done: done_o=%b required 1", done_o); end
        checks++; if (got_q.size() != NPAIRS) begin
            errors++; $display("FAIL sweep_count: triples=%0d required %0d", got_q.size(), NPAIRS);
        end
        for (int i = 0; i < NPAIRS && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL sweep_triple[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        repeat (20) @(posedge clk_i);
        #1;
        checks++; if (starts != NPAIRS) begin errors++; $display("FAIL sweep_starts: starts=%0d required %0d", starts, NPAIRS); end
        checks++; if ({done_o, busy_o, err_o} !== 3'b100) begin
            errors++; $display("FAIL sweep_finish_flags: done,busy,err=%b required 100", {done_o, busy_o, err_o});
        end
        checks++; if (dbl_start) begin errors++; $display("FAIL sweep_start_width: start_o high two cycles, required one"); end
    endtask

    task automatic test_restart();
        int n;
        @(posedge clk_i); #1; run_i = 1'b0;
        @(posedge clk_i); #1;
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL restart_done_clear: done_o=%b required 0", done_o); end
        checks++; if (a_bo !== afv || b_bo !== bfv) begin
            errors++; $display("FAIL restart_reload: a,b=%0d,%0d required %0d,%0d", a_bo, b_bo, afv, bfv);
        end
        got_q.delete(); starts = 0;
        run_i = 1'b1;
        n = 0;
        while (!done_o && n < 2000) begin @(posedge clk_i); #1; n++; end
        checks++; if (got_q.size() != NPAIRS || starts != NPAIRS) begin
            errors++; $display("FAIL restart_count: triples=%0d starts=%0d required %0d", got_q.size(), starts, NPAIRS);
        end
        for (int i = 0; i < NPAIRS && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL restart_triple[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n, st;
        logic [31:0] snap;
        do_reset();
        rst_i = 1'b0;
        res_ready_i = 1'b0;
        got_q.delete(); starts = 0; dbl_start = 1'b0;
        run_i = 1'b1;
        n = 0;
        while (!res_valid_o && n < 200) begin @(posedge clk_i); #1; n++; end
        res_ready_i = 1'b1;
        @(posedge clk_i); #1;
        res_ready_i = 1'b0;
        n = 0;
        while (!res_valid_o && n < 200) begin @(posedge clk_i); #1; n++; end
        checks++; if (res_valid_o !== 1'b1) begin errors++; $display("FAIL bp_second_valid: res_valid_o=%b required 1", res_valid_o); end
        snap = {res_a_bo, res_b_bo, res_y_bo};
        st = starts;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            checks++; if (res_valid_o !== 1'b1 || {res_a_bo, res_b_bo, res_y_bo} !== snap || starts != st) begin
                errors++; $display("FAIL bp_hold[%0d]: valid=%b res=%h starts=%0d required 1 %h %0d",
                                   i, res_valid_o, {res_a_bo, res_b_bo, res_y_bo}, starts, snap, st);
            end
        end
        res_ready_i = 1'b1;
        n = 0;
        while (!done_o && n < 2000) begin @(posedge clk_i); #1; n++; end
        checks++; if (got_q.size() != NPAIRS || starts != NPAIRS) begin
            errors++; $display("FAIL bp_count: triples=%0d starts=%0d required %0d", got_q.size(), starts, NPAIRS);
        end
        for (int i = 0; i < NPAIRS && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_triple[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++; if (dbl_start) begin errors++; $display("FAIL bp_start_width: start_o high two cycles, required one"); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [W-1:0] b_second;
        b_second = bfv + W'(1);
        do_reset();
        rst_i = 1'b0;
        run_i = 1'b1;
        n = 0;
        while (!(a_bo == afv && b_bo == b_second && busy_i) && n < 500) begin @(posedge clk_i); #1; n++; end
        checks++; if (!(a_bo == afv && b_bo == b_second && busy_i)) begin
            errors++; $display("FAIL mid_reach_wait_done: a,b,busy_i=%0d,%0d,%b required %0d,%0d,1", a_bo, b_bo, busy_i, afv, b_second);
        end
        // busy_i was already high at the last edge, so the sweep is in its wait-for-done phase
        rst_i = 1'b1;
        run_i = 1'b0;
        @(posedge clk_i); #1;
        got_q.delete(); starts = 0;
        checks++; if ({start_o, res_valid_o, busy_o, done_o, err_o} !== 5'b0 || {res_a_bo, res_b_bo, res_y_bo} !== 32'h0) begin
            errors++; $display("FAIL mid_reset_outputs: flags=%b res=%h required 0 0",
                               {start_o, res_valid_o, busy_o, done_o, err_o}, {res_a_bo, res_b_bo, res_y_bo});
        end
        checks++; if (a_bo !== afv || b_bo !== bfv) begin
            errors++; $display("FAIL mid_reset_ab: a,b=%0d,%0d required %0d,%0d", a_bo, b_bo, afv, bfv);
        end
        @(posedge clk_i); #1;
        checks++; if (starts != 0) begin errors++; $display("FAIL mid_reset_no_start: starts=%0d required 0", starts); end
        rst_i = 1'b0;
        run_i = 1'b1;
        n = 0;
        while (!done_o && n < 2000) begin @(posedge clk_i); #1; n++; end
        checks++; if (got_q.size() != NPAIRS || starts != NPAIRS) begin
            errors++; $display("FAIL mid_restart_count: triples=%0d starts=%0d required %0d", got_q.size(), starts, NPAIRS);
        end
        for (int i = 0; i < NPAIRS && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL mid_restart_triple[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        rst_i = 1'b0;
        no_ack = 1'b1;
        starts = 0;
        run_i = 1'b1;
        n = 0;
        while (!start_o && n < 50) begin @(posedge clk_i); #1; n++; end
        checks++; if (start_o !== 1'b1) begin errors++; $display("FAIL to_start: start_o=%b required 1", start_o); end
        // n counts the waiting cycles strictly between the start cycle and the first err cycle
        n = 0;
        while (n < 40) begin
            @(posedge clk_i); #1;
            if (err_o) break;
            n++;
        end
        checks++; if (err_o !== 1'b1 || n != TO) begin
            errors++; $display("FAIL to_latency: err_o=%b after %0d wait cycles required 1 after %0d", err_o, n, TO);
        end
        checks++; if ({done_o, busy_o} !== 2'b10) begin
            errors++; $display("FAIL to_finish: done,busy=%b required 10", {done_o, busy_o});
        end
        repeat (20) @(posedge clk_i);
        #1;
        checks++; if (starts != 1) begin errors++; $display("FAIL to_no_restart: starts=%0d required 1", starts); end
        run_i = 1'b0;
        @(posedge clk_i); #1;
        checks++; if (err_o !== 1'b1 || done_o !== 1'b0) begin
            errors++; $display("FAIL to_sticky: err,done=%b%b required 10", err_o, done_o);
        end
        do_reset();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL to_reset_clear: err_o=%b required 0", err_o); end
        rst_i = 1'b0;
        no_ack = 1'b0;
    endtask

    initial begin
        afv = W'(AF);
        bfv = W'(BF);
        for (int a = AF; a <= AL; a++)
            for (int b = BF; b <= BL; b++)
                exp_q.push_back({8'(a), 8'(b), 16'(a * b)});
        test_reset();
        test_sweep();
        test_restart();
        test_backpressure();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
